// File: rtl/nexys_starship_shield_ctrl_pkg.sv
// Shared definitions for the Nexys Starship shield controller.
package nexys_starship_shield_ctrl_pkg;

    // One-hot state encoding; bit position matches the q_* output order.
    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_ARMED  = 5'b00010;
    localparam logic [4:0] S_SHIELD = 5'b00100;
    localparam logic [4:0] S_COOL   = 5'b01000;
    localparam logic [4:0] S_OVER   = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE   = S_IDLE,
        ST_ARMED  = S_ARMED,
        ST_SHIELD = S_SHIELD,
        ST_COOL   = S_COOL,
        ST_OVER   = S_OVER
    } state_t;

    // Lane indices, shared with the lane selector and the monster FSMs.
    localparam int LANE_UP    = 0;
    localparam int LANE_DOWN  = 1;
    localparam int LANE_LEFT  = 2;
    localparam int LANE_RIGHT = 3;

    localparam int DEF_SHIELD_HOLD = 4;
    localparam int DEF_COOLDOWN    = 6;

    // Lane index to one-hot lane vector.
    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/nexys_starship_shield_ctrl_kill_counter.sv
// Counts monsters destroyed under an active shield, saturating at all-ones.
module starship_kill_counter #(
    parameter int SCORE_W = 16
) (
    input  logic               timer_clk,
    input  logic               Reset,
    input  logic [3:0]         monster_flags,
    input  logic [3:0]         kill_mask,
    input  logic               clear,
    input  logic               freeze,
    output logic [SCORE_W-1:0] score
);

    logic [3:0] monster_q;
    logic       kill;

    // A kill is a monster disappearing on a lane that is currently protected.
    assign kill = |(monster_q & ~monster_flags & kill_mask);

    // Edge-detect register and saturating score counter.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            monster_q <= '0;
            score     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            monster_q <= monster_flags;
            if (clear) begin
                score <= '0;
            end else if (!freeze && kill && score != '1) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

endmodule

// File: rtl/nexys_starship_shield_ctrl.sv
// Player shield controller: hold window, cooldown, score and gameover broadcast.
module nexys_starship_shield_ctrl
    import nexys_starship_shield_ctrl_pkg::*;
#(
    parameter int SHIELD_HOLD = DEF_SHIELD_HOLD,
    parameter int COOLDOWN    = DEF_COOLDOWN,
    parameter int SCORE_W     = 16
) (
    input  logic               timer_clk,
    input  logic               Reset,
    input  logic               play_flag,
    input  logic               btn_shield,
    input  logic [1:0]         dir_sel,
    input  logic [3:0]         monster_flags,
    input  logic [3:0]         lane_gameover,
    output logic [3:0]         shield,
    output logic               gameover_ctrl,
    output logic [SCORE_W-1:0] score,
    output logic               q_Idle,
    output logic               q_Armed,
    output logic               q_Shield,
    output logic               q_Cool,
    output logic               q_Over
);

    localparam int HOLD_W = (SHIELD_HOLD > 1) ? $clog2(SHIELD_HOLD) : 1;
    localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    state_t            state, next_state;
    logic [1:0]        lane_q, next_lane;
    logic [HOLD_W-1:0] hold_cnt, next_hold;
    logic [COOL_W-1:0] cool_cnt, next_cool;
    logic              score_clear;
    logic              any_gameover;
    logic              first_cool;
    logic [3:0]        kill_mask;

    assign any_gameover = |lane_gameover;

    // Next-state logic; gameover outranks every other transition.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        next_state  = state;
        next_lane   = lane_q;
        next_hold   = hold_cnt;
        next_cool   = cool_cnt;
        score_clear = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (play_flag) begin
                    next_state  = ST_ARMED;
                    score_clear = 1'b1;
                end
            end
            ST_ARMED: begin
                if (any_gameover)    next_state = ST_OVER;
                else if (!play_flag) next_state = ST_IDLE;
                else if (btn_shield) begin
                    next_state = ST_SHIELD;
                    next_lane  = dir_sel;
                    next_hold  = HOLD_W'(SHIELD_HOLD - 1);
                end
            end
            ST_SHIELD: begin
                if (any_gameover)    next_state = ST_OVER;
                else if (!play_flag) next_state = ST_IDLE;
                else if (hold_cnt == '0) begin
                    next_state = ST_COOL;
                    next_cool  = COOL_W'(COOLDOWN - 1);
                end else begin
                    next_hold = hold_cnt - HOLD_W'(1);
                end
            end
            ST_COOL: begin
                if (any_gameover)    next_state = ST_OVER;
                else if (!play_flag) next_state = ST_IDLE;
                else if (cool_cnt == '0) next_state = ST_ARMED;
                else next_cool = cool_cnt - COOL_W'(1);
            end
            ST_OVER: begin
                if (!play_flag) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, counters and the registered shield drive.
    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            lane_q   <= '0;
            hold_cnt <= '0;
            cool_cnt <= '0;
            shield   <= '0;
        end else begin
            state    <= next_state;
            lane_q   <= next_lane;
            hold_cnt <= next_hold;
            cool_cnt <= next_cool;
            shield   <= (next_state == ST_SHIELD) ? lane_onehot(next_lane) : 4'b0000;
        end
    end

    assign q_Idle        = state[0];
    assign q_Armed       = state[1];
    assign q_Shield      = state[2];
    assign q_Cool        = state[3];
    assign q_Over        = state[4];
    assign gameover_ctrl = state[4];

    // The first cooldown tick still credits the released lane, absorbing lane lag.
    assign first_cool = (state == ST_COOL) && (cool_cnt == COOL_W'(COOLDOWN - 1));
    assign kill_mask  = shield | (first_cool ? lane_onehot(lane_q) : 4'b0000);

    starship_kill_counter #(
        .SCORE_W(SCORE_W)
    ) u_kill_counter (
        .timer_clk    (timer_clk),
        .Reset        (Reset),
        .monster_flags(monster_flags),
        .kill_mask    (kill_mask),
        .clear        (score_clear),
        .freeze       (state == ST_OVER),
        .score        (score)
    );

endmodule

// File: tb/tb_nexys_starship_shield_ctrl.sv
// Scoreboard bench for the shield controller: directed stimulus, queued expectations.
module tb_nexys_starship_shield_ctrl;

    localparam logic [4:0] Q_IDLE   = 5'b00001;
    localparam logic [4:0] Q_ARMED  = 5'b00010;
    localparam logic [4:0] Q_SHIELD = 5'b00100;
    localparam logic [4:0] Q_COOL   = 5'b01000;
    localparam logic [4:0] Q_OVER   = 5'b10000;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  q;
        logic [3:0]  shield;
        logic        go;
        logic [15:0] score;
        logic [1:0]  score2;
    } exp_t;

    logic        timer_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        play_flag = 1'b0;
    logic        btn_shield = 1'b0;
    logic [1:0]  dir_sel = 2'd0;
    logic [3:0]  monster_flags = 4'b0000;
    logic [3:0]  lane_gameover = 4'b0000;

    logic [3:0]  shield, shield2;
    logic        gameover_ctrl, gameover_ctrl2;
    logic [15:0] score;
    logic [1:0]  score2;
    logic        q_Idle, q_Armed, q_Shield, q_Cool, q_Over;
    logic        q_Idle2, q_Armed2, q_Shield2, q_Cool2, q_Over2;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   score_m = 0;
    exp_t sb[$];
    exp_t rq[$];
    exp_t m_e;
    exp_t r_e;

    nexys_starship_shield_ctrl dut (
        .timer_clk(timer_clk), .Reset(Reset), .play_flag(play_flag),
        .btn_shield(btn_shield), .dir_sel(dir_sel), .monster_flags(monster_flags),
        .lane_gameover(lane_gameover), .shield(shield), .gameover_ctrl(gameover_ctrl),
        .score(score), .q_Idle(q_Idle), .q_Armed(q_Armed), .q_Shield(q_Shield),
        .q_Cool(q_Cool), .q_Over(q_Over)
    );

    nexys_starship_shield_ctrl #(.SCORE_W(2)) dut_sat (
        .timer_clk(timer_clk), .Reset(Reset), .play_flag(play_flag),
        .btn_shield(btn_shield), .dir_sel(dir_sel), .monster_flags(monster_flags),
        .lane_gameover(lane_gameover), .shield(shield2), .gameover_ctrl(gameover_ctrl2),
        .score(score2), .q_Idle(q_Idle2), .q_Armed(q_Armed2), .q_Shield(q_Shield2),
        .q_Cool(q_Cool2), .q_Over(q_Over2)
    );

    always #5 timer_clk = ~timer_clk;

    always @(posedge timer_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    task automatic compare(input exp_t e);
        check({e.name, "/state"}, 32'({q_Over, q_Cool, q_Shield, q_Armed, q_Idle}), 32'(e.q));
        check({e.name, "/shield"}, 32'(shield), 32'(e.shield));
        check({e.name, "/gameover"}, 32'(gameover_ctrl), 32'(e.go));
        check({e.name, "/score"}, 32'(score), 32'(e.score));
        check({e.name, "/score_sat"}, 32'(score2), 32'(e.score2));
    endtask

    function automatic exp_t mk(input int c, input string n, input logic [4:0] q,
                                input logic [3:0] sh, input int sc);
        exp_t e;
        e.cyc    = c;
        e.name   = n;
        e.q      = q;
        e.shield = sh;
        e.go     = (q == Q_OVER);
        e.score  = 16'(sc);
        e.score2 = (sc > 3) ? 2'd3 : 2'(sc);
        return e;
    endfunction

    task automatic push(input int c, input string n, input logic [4:0] q,
                        input logic [3:0] sh, input int sc);
        sb.push_back(mk(c, n, q, sh, sc));
    endtask

    task automatic tick();
        @(posedge timer_clk);
        #1;
    endtask

    // Monitor: compares every expectation due on this tick, away from the active edge.
    always @(negedge timer_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            if (m_e.cyc < cyc) check({m_e.name, "/missed"}, 32'(cyc), 32'(m_e.cyc));
            else compare(m_e);
        end
    end

    // Monitor for asynchronous reset: outputs must clear without a clock edge.
    always @(posedge Reset) begin
        #1;
        while (rq.size() > 0) begin
            r_e = rq.pop_front();
            compare(r_e);
        end
    end

    // One shield activation: SHIELD_HOLD=4 ticks raised, COOLDOWN=6 ticks low, then armed.
    task automatic do_press(input string name, input logic [1:0] dir, input int fall_t,
                            input logic [3:0] fall_bits, input bit kill, input bit second);
        int c0;
        int sc;
        c0 = cyc;
        btn_shield    = 1'b1;
        dir_sel       = dir;
        monster_flags = 4'b1111;
        for (int k = 1; k <= 11; k++) begin
            sc = score_m + ((kill && k > fall_t) ? 1 : 0);
            if (k <= 4)       push(c0 + k, name, Q_SHIELD, 4'b0001 << dir, sc);
            else if (k <= 10) push(c0 + k, name, Q_COOL, 4'b0000, sc);
            else              push(c0 + k, name, Q_ARMED, 4'b0000, sc);
        end
        for (int t = 1; t <= 11; t++) begin
            tick();
            btn_shield = second && (t == 2);
            if (t == fall_t) monster_flags = monster_flags & ~fall_bits;
        end
        if (kill) score_m++;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        tick();
        push(cyc + 1, "reset", Q_IDLE, 4'b0000, 0);
        tick();
        Reset = 1'b0;
        push(cyc + 1, "idle", Q_IDLE, 4'b0000, 0);
        tick();
        play_flag = 1'b1;
        push(cyc + 1, "start", Q_ARMED, 4'b0000, 0);
        tick();

        do_press("single_r", 2'd3, 0, 4'b0000, 1'b0, 1'b0);
        do_press("double_r", 2'd3, 0, 4'b0000, 1'b0, 1'b1);
        do_press("kill_r",   2'd3, 1, 4'b1000, 1'b1, 1'b0);
        do_press("miss_d",   2'd3, 1, 4'b0010, 1'b0, 1'b0);
        do_press("cool1_u",  2'd0, 5, 4'b0001, 1'b1, 1'b0);
        do_press("cool2_u",  2'd0, 6, 4'b0001, 1'b0, 1'b0);
        do_press("kill_d",   2'd1, 2, 4'b0010, 1'b1, 1'b0);
        do_press("kill_l",   2'd2, 4, 4'b0100, 1'b1, 1'b0);
        do_press("kill_r2",  2'd3, 3, 4'b1000, 1'b1, 1'b0);

        // Gameover during SHIELD, then back to idle and a fresh game.
        c0 = cyc;
        btn_shield = 1'b1; dir_sel = 2'd2;
        push(c0 + 1, "go_shield", Q_SHIELD, 4'b0100, 5);
        tick(); btn_shield = 1'b0; lane_gameover = 4'b0010;
        push(c0 + 2, "go_enter", Q_OVER, 4'b0000, 5);
        tick(); lane_gameover = 4'b0000;
        push(c0 + 3, "go_hold", Q_OVER, 4'b0000, 5);
        tick(); play_flag = 1'b0;
        push(c0 + 4, "go_idle", Q_IDLE, 4'b0000, 5);
        tick(); play_flag = 1'b1;
        push(c0 + 5, "go_restart", Q_ARMED, 4'b0000, 0);
        tick();
        // Gameover and press on the same tick: gameover wins.
        btn_shield = 1'b1; dir_sel = 2'd1; lane_gameover = 4'b0001;
        push(c0 + 6, "go_prio", Q_OVER, 4'b0000, 0);
        tick(); btn_shield = 1'b0; lane_gameover = 4'b0000;
        push(c0 + 7, "go_prio_hold", Q_OVER, 4'b0000, 0);
        tick(); play_flag = 1'b0;
        push(c0 + 8, "go_prio_idle", Q_IDLE, 4'b0000, 0);
        tick(); play_flag = 1'b1;
        push(c0 + 9, "go_prio_restart", Q_ARMED, 4'b0000, 0);
        tick();

        // Asynchronous reset in the middle of a shield with a nonzero score.
        btn_shield = 1'b1; dir_sel = 2'd3; monster_flags = 4'b1111;
        push(c0 + 10, "rst_shield", Q_SHIELD, 4'b1000, 0);
        tick(); btn_shield = 1'b0; monster_flags = 4'b0111;
        push(c0 + 11, "rst_kill", Q_SHIELD, 4'b1000, 1);
        tick();
        @(negedge timer_clk);
        #1;
        rq.push_back(mk(0, "rst_async", Q_IDLE, 4'b0000, 0));
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        push(c0 + 12, "rst_rearm", Q_ARMED, 4'b0000, 0);
        tick();
        tick();
        tick();
        check("leftover_sb", 32'(sb.size()), 32'd0);
        check("leftover_rq", 32'(rq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
